mux_4x1_rr_arb: RTL
===================

// Module: mux_4x1_rr_arb
// PURPOSE
//  Gathering end of the 4-way demux path: merges four valid/ready input channels into one output channel.
//  Arbitration is round-robin with an optional burst hold.
//  Output is registered and carries the 2-bit source ID, so downstream logic can re-steer the data through a 1-to-4 demux.
//  Sits between four producer lanes and a single shared consumer.
// PARAMETERS
//  DATA_W     8   width of each data word
//  MAX_BURST  1   max consecutive accepted words from one channel before rotating (>=1; 1 = pure round-robin)
// PORTS
//  clk_i         input   1         single clock, rising edge
//  rst_i         input   1         asynchronous reset, active-high
//  in_valid_i    input   4         per-channel valid; bit n = channel n
//  in_data_i     input   4*DATA_W  channel n data at [n*DATA_W +: DATA_W]
//  in_ready_o    output  4         per-channel ready; at most one bit set
//  out_valid_o   output  1         registered output valid
//  data_out_o    output  DATA_W    registered output data
//  sel_o         output  2         registered source channel ID of data_out_o
//  out_ready_i   input   1         downstream ready
// BEHAVIOUR
//  Reset (async, immediate on rst_i=1):
//   - out_valid_o=0, data_out_o=0, sel_o=0.
//   - ptr=3 (last granted channel), burst_cnt=MAX_BURST.
//   - in_ready_o=0 while rst_i=1.
//  Transfers:
//   - load = ~out_valid_o | out_ready_i.
//   - Input transfer on channel n: in_valid_i[n] & in_ready_o[n] at a clock edge.
//   - Output transfer: out_valid_o & out_ready_i at a clock edge.
//  Grant (combinational):
//   - hold = in_valid_i[ptr] & (burst_cnt < MAX_BURST).
//   - grant = ptr if hold; otherwise the first valid channel searching ptr+1, ptr+2, ... (mod 4).
//   - No valid channel: no grant.
//  Ready and load:
//   - in_ready_o[n] = load & (n==grant) & in_valid_i[n].
//   - Combinational path out_ready_i -> in_ready_o is permitted.
//   - On an input transfer: data_out_o<=in_data_i[grant], sel_o<=grant, out_valid_o<=1.
//   - Same edge as an input transfer: if grant==ptr then burst_cnt<=burst_cnt+1; else ptr<=grant and burst_cnt<=1.
//   - Output transfer with no input transfer: out_valid_o<=0; data_out_o and sel_o keep their value.
//  Latency and throughput:
//   - Latency: 1 cycle from input transfer to out_valid_o.
//   - Throughput: 1 word/cycle when out_ready_i=1.
//  Backpressure:
//   - out_valid_o=1 & out_ready_i=0 -> in_ready_o=0000.
//   - data_out_o, sel_o, ptr and burst_cnt are stable; no word is lost or duplicated.
//  Boundary conditions:
//   - Pointer wraps 3->0.
//   - A channel dropping valid mid-burst forfeits the hold; the search continues from ptr+1.
//   - Simultaneous output transfer and input transfer on the same edge: register is replaced, out_valid_o stays 1.
//   - Reset mid-operation drops the registered word; the first post-reset priority is channel 0.
//  Widths:
//   - burst_cnt width = $clog2(MAX_BURST+1).
//   - burst_cnt saturates at MAX_BURST and never wraps.
// STRUCTURE
//  - Shared package mux_arb_pkg: NUM_CH=4, CH_ID_W=2, and a localparam for the reset pointer value 2'd3.
//  - Sub-module rr_pick4: combinational inputs req[3:0] and ptr[1:0]; outputs gnt_id[1:0] and gnt_vld.
//    It finds the first request after ptr, with wrap-around.
//  - The top module adds the hold override, the output register and the ptr/burst_cnt state.
// TESTING
//  1. Reset: assert rst_i mid-cycle
//     -> out_valid_o=0, data_out_o=0, sel_o=0, in_ready_o=0000 immediately, without a clock edge.
//  2. Only channel 2 streams 8'hA1, 8'hA2, 8'hA3 with out_ready_i=1
//     -> outputs appear one cycle after each accept, sel_o=2, no bubbles.
//  3. MAX_BURST=1, all four channels valid continuously, out_ready_i=1
//     -> sel_o sequence 0,1,2,3,0,1; in_ready_o one-hot 0001,0010,0100,1000.
//  4. MAX_BURST=2, same stimulus as test 3
//     -> sel_o sequence 0,0,1,1,2,2,3,3,0.
//     Then drop channel 1 valid after its first word -> sequence continues 2,2.
//  5. Backpressure: out_ready_i=0 for 3 cycles while channels 0 and 3 are valid
//     -> data_out_o/sel_o frozen, in_ready_o=0000.
//     On release -> the frozen word is delivered once, then arbitration resumes from the next channel.
//  6. Channels 1 and 2 valid, with an output transfer and an input transfer on the same edge every cycle
//     -> out_valid_o stays 1 and the 1,2,1,2 order is preserved.
//     A reset pulse in the middle -> the next grant goes to the lowest valid channel (1).

Source files
------------

// File: rtl/mux_arb_pkg.sv
// ============================================================================
// Module  : mux_arb_pkg
// Purpose : Shared constants and types for the 4-to-1 round-robin merge arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mux_arb_pkg;

    // Number of producer lanes merged onto the shared consumer
    localparam int NUM_CH  = 4;
    // Width of a channel identifier
    localparam int CH_ID_W = 2;
    // Pointer value after reset: "channel 3 was last served" so channel 0 wins first
    localparam logic [CH_ID_W-1:0] RST_PTR = 2'd3;

    // Result of one arbitration round
    typedef struct packed {
        logic               vld;
        logic [CH_ID_W-1:0] id;
    } grant_t;

    // Channel that sits 'step' positions after 'id', wrapping modulo NUM_CH
    function automatic logic [CH_ID_W-1:0] ch_after(
        input logic [CH_ID_W-1:0] id,
        input logic [CH_ID_W-1:0] step
    );
        return id + step;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_4x1_rr_arb_rr_pick4.sv
// ============================================================================
// Module  : rr_pick4
// Purpose : Combinational round-robin picker. Returns the first requesting
//           channel strictly after ptr, wrapping; ptr itself is examined last.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_CH-1:0]  req,
    input  logic [CH_ID_W-1:0] ptr,
    output logic [CH_ID_W-1:0] gnt_id,
    output logic               gnt_vld
);

    // Scan farthest-to-nearest so the nearest requester after ptr is the last
    // (and therefore winning) assignment. Step NUM_CH truncates to 0 = ptr.
    always_comb begin
        logic [CH_ID_W-1:0] w_idx;
        gnt_id  = ptr;
        gnt_vld = 1'b0;
        w_idx   = ptr;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_idx = ch_after(ptr, CH_ID_W'(k));
            if (req[w_idx]) begin
                gnt_id  = w_idx;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_4x1_rr_arb.sv
// ============================================================================
// Module  : mux_4x1_rr_arb
// Purpose : Merges four valid/ready producer lanes into one registered output
//           channel tagged with its 2-bit source ID. Round-robin arbitration
//           with an optional burst hold of up to MAX_BURST words per channel.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_4x1_rr_arb
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 1
)
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_CH-1:0]        in_valid_i,
    input  logic [NUM_CH*DATA_W-1:0] in_data_i,
    output logic [NUM_CH-1:0]        in_ready_o,
    output logic                     out_valid_o,
    output logic [DATA_W-1:0]        data_out_o,
    output logic [CH_ID_W-1:0]       sel_o,
    input  logic                     out_ready_i
);

    localparam int                CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  c_MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]  c_ONE     = CNT_W'(1);

    // Arbitration state: last granted channel and words taken from it in a row
    logic [CH_ID_W-1:0] r_ptr;
    logic [CNT_W-1:0]   r_burst_cnt;

    // Output register
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_data;
    logic [CH_ID_W-1:0] r_sel;

    logic               w_load;
    logic               w_hold;
    logic [CH_ID_W-1:0] w_pick_id;
    logic               w_pick_vld;
    grant_t             w_grant;
    logic               w_xfer;
    logic [DATA_W-1:0]  w_ch_data [NUM_CH];
    logic [DATA_W-1:0]  w_gnt_data;

    // Split the flat data bus into per-channel words
    generate
        for (genvar n = 0; n < NUM_CH; n++) begin : g_unpack
            assign w_ch_data[n] = in_data_i[n*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick4 u_pick (
        .req     (in_valid_i),
        .ptr     (r_ptr),
        .gnt_id  (w_pick_id),
        .gnt_vld (w_pick_vld)
    );

    // The output register can take a new word when empty or being drained
    assign w_load = ~r_out_valid | out_ready_i;

    // Last-served channel keeps the grant while still valid and under its burst budget
    assign w_hold = in_valid_i[r_ptr] & (r_burst_cnt < c_MAX_CNT);

    // Hold overrides the rotating pick
    always_comb begin
        w_grant.vld = w_hold | w_pick_vld;
        w_grant.id  = w_hold ? r_ptr : w_pick_id;
    end

    // One-hot ready towards the granted, valid channel; forced low during reset
    always_comb begin
        in_ready_o = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            in_ready_o[n] = ~rst_i & w_load & w_grant.vld
                          & (w_grant.id == CH_ID_W'(n)) & in_valid_i[n];
        end
    end

    assign w_xfer     = |in_ready_o;
    assign w_gnt_data = w_ch_data[w_grant.id];

    // Output register: capture on accept, clear valid when drained with nothing new
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_data      <= '0;
            r_sel       <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_data      <= w_gnt_data;
            r_sel       <= w_grant.id;
        end else if (r_out_valid && out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    // Pointer/burst tracking: extend the run on a repeat grant, restart it on a switch
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr       <= RST_PTR;
            r_burst_cnt <= c_MAX_CNT;
        end else if (w_xfer) begin
            if (w_grant.id == r_ptr) begin
                if (r_burst_cnt < c_MAX_CNT) begin
                    r_burst_cnt <= r_burst_cnt + c_ONE;
                end
            end else begin
                r_ptr       <= w_grant.id;
                r_burst_cnt <= c_ONE;
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign data_out_o  = r_data;
    assign sel_o       = r_sel;

endmodule

`default_nettype wire
